// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - cacheline burst memory responder with programmable access latency
//
// Serves one cacheline (BEATS x BEAT_W bits) per transaction from an internal line array.
// A request is accepted, waits READ_LAT/WRITE_LAT cycles, then streams BEATS response beats,
// then spends one turnaround cycle before the next accept.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   mem_read     line read request, held until the last mem_resp beat
//   mem_write    line write request, held until the last mem_resp beat
//   mem_address  byte address of the line; offset bits ignored, sampled at accept
//   mem_wdata    write beat k, shown while k response beats have completed
//   mem_rdata    registered read beat, zero whenever mem_resp is low
//   mem_resp     registered beat strobe, high BEATS consecutive cycles per transaction
//   proto_err    sticky protocol-violation flag, cleared only by reset
module burst_mem_responder #(
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 64,
  parameter int BEATS     = 4,
  parameter int LINES     = 256,
  parameter int READ_LAT  = 10,
  parameter int WRITE_LAT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [BEAT_W-1:0] mem_wdata,
  output logic [BEAT_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              proto_err
);

  localparam int LINE_W  = BEATS * BEAT_W;
  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam int IDX_W   = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  logic [1:0]         state;
  logic               op_wr;
  logic [IDX_W-1:0]   idx;
  logic [LAT_W-1:0]   lat_cnt;
  logic [BEAT_CW-1:0] beat_cnt;
  logic [LINE_W-1:0]  wbuf;
  logic [LINE_W-1:0]  mem [LINES];

  logic               req;
  logic               one_req;
  logic [LAT_W-1:0]   lat_last;
  logic [BEAT_CW-1:0] beat_nxt;
  logic [IDX_W-1:0]   acc_idx;
  logic [LINE_W-1:0]  line_rd;
  logic               unused_addr;

  // LINES is a power of two, so "modulo LINES" is just the low index bits above the line offset.
  assign acc_idx     = mem_address[OFF_W +: IDX_W];
  assign unused_addr = ^{mem_address[ADDR_W-1:OFF_W+IDX_W], mem_address[OFF_W-1:0]};

  assign req      = op_wr ? mem_write : mem_read;
  assign one_req  = mem_read ^ mem_write;
  assign lat_last = op_wr ? LAT_W'(WRITE_LAT - 1) : LAT_W'(READ_LAT - 1);
  assign beat_nxt = beat_cnt + 1'b1;
  assign line_rd  = mem[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      idx       <= '0;
      lat_cnt   <= '0;
      beat_cnt  <= '0;
      wbuf      <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_read && mem_write) begin
            proto_err <= 1'b1;
          end else if (one_req) begin
            state   <= S_WAIT;
            op_wr   <= mem_write;
            idx     <= acc_idx;
            lat_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (!req) begin
            // host withdrew before any beat: a legal abort
            state <= S_IDLE;
          end else if (lat_cnt == lat_last) begin
            state     <= S_BURST;
            beat_cnt  <= '0;
            mem_resp  <= 1'b1;
            mem_rdata <= op_wr ? '0 : line_rd[0 +: BEAT_W];
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_BURST: begin
          if (!req) begin
            proto_err <= 1'b1;
            state     <= S_IDLE;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
          end else begin
            if (op_wr) wbuf[beat_cnt*BEAT_W +: BEAT_W] <= mem_wdata;
            if (beat_cnt == BEAT_CW'(BEATS - 1)) begin
              state     <= S_TURN;
              mem_resp  <= 1'b0;
              mem_rdata <= '0;
            end else begin
              beat_cnt  <= beat_nxt;
              mem_rdata <= op_wr ? '0 : line_rd[beat_nxt*BEAT_W +: BEAT_W];
            end
          end
        end
        default: begin
          // Turnaround: the write commit happens on this edge. A request still held here is
          // taken as the next accept so back-to-back lines cost LAT+BEATS+1 cycles.
          if (one_req) begin
            state   <= S_WAIT;
            op_wr   <= mem_write;
            idx     <= acc_idx;
            lat_cnt <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; only a completed burst reaches TURN.
  always_ff @(posedge clk) begin
    if (rst && state == S_TURN && op_wr) mem[idx] <= wbuf;
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - directed self-checking bench for burst_mem_responder
module tb_burst_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  int vectors = 0;
  int errors  = 0;

  burst_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request is driven now; the next rising edge is the accept edge.
  task automatic do_line(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] eline,
                         input bit hold, input bit eperr);
    int early;
    mem_address = addr;
    mem_wdata   = wline[63:0];
    mem_read    = !wr;
    mem_write   = wr;
    early       = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_resp !== 1'b0) early++;
    end
    chk({tag, "_resp_before_lat"}, 64'(early), 64'd0);
    for (int b = 0; b < 4; b++) begin
      tick();
      mem_wdata = wline[b*64 +: 64];
      chk($sformatf("%s_resp_beat%0d", tag, b), 64'(mem_resp), 64'd1);
      if (!wr) chk($sformatf("%s_rdata_beat%0d", tag, b), mem_rdata, eline[b*64 +: 64]);
    end
    tick();
    chk({tag, "_turn_resp"}, 64'(mem_resp), 64'd0);
    chk({tag, "_turn_rdata"}, mem_rdata, 64'd0);
    chk({tag, "_proto_err"}, 64'(proto_err), 64'(eperr));
    if (!hold) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      tick();
    end
  endtask

  logic [255:0] line_a, line_b, line_c, line_d;
  int cnt;

  initial begin
    line_a = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    line_b = {64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555};
    line_c = {64'hdddddddddddddddd, 64'hcccccccccccccccc, 64'hbbbbbbbbbbbbbbbb, 64'haaaaaaaaaaaaaaaa};
    line_d = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f0f0f0f0f0f0f0f, 64'hf0f0f0f0f0f0f0f0};

    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    #12;
    chk("reset_resp", 64'(mem_resp), 64'd0);
    chk("reset_rdata", mem_rdata, 64'd0);
    chk("reset_proto_err", 64'(proto_err), 64'd0);
    rst = 1'b1;
    tick();

    // Line write then read through an aliasing address in the same line.
    do_line("wr40", 1'b1, 32'h40, line_a, '0, 1'b0, 1'b0);
    do_line("rd5f", 1'b0, 32'h5f, '0, line_a, 1'b0, 1'b0);

    // Withdraw a read partway through the latency window: legal abort.
    mem_address = 32'h40; mem_read = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mem_read = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mem_resp !== 1'b0) cnt++;
    end
    chk("abort_wait_resp", 64'(cnt), 64'd0);
    chk("abort_wait_proto_err", 64'(proto_err), 64'd0);
    do_line("rd40_after_abort", 1'b0, 32'h40, '0, line_a, 1'b0, 1'b0);

    // Write drops mid-burst: flagged, and the old line survives.
    do_line("wr80", 1'b1, 32'h80, line_c, '0, 1'b0, 1'b0);
    mem_address = 32'h80; mem_write = 1'b1; mem_wdata = line_b[63:0];
    for (int i = 0; i < 10; i++) tick();
    tick();
    tick(); mem_wdata = line_b[127:64];
    tick(); mem_wdata = line_b[191:128];
    chk("wrdrop_third_beat_resp", 64'(mem_resp), 64'd1);
    mem_write = 1'b0;
    tick();
    chk("wrdrop_resp", 64'(mem_resp), 64'd0);
    chk("wrdrop_proto_err", 64'(proto_err), 64'd1);
    tick();
    do_line("rd80_old", 1'b0, 32'h80, '0, line_c, 1'b0, 1'b1);

    // Reset clears the sticky flag; both requests together set it without a response.
    #2 rst = 1'b0;
    #1 chk("rst_clears_proto_err", 64'(proto_err), 64'd0);
    rst = 1'b1;
    tick();
    mem_address = 32'h40; mem_read = 1'b1; mem_write = 1'b1;
    tick();
    chk("both_req_proto_err", 64'(proto_err), 64'd1);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (mem_resp !== 1'b0) cnt++;
    end
    chk("both_req_no_resp", 64'(cnt), 64'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();

    // Asynchronous reset in the middle of a read burst.
    mem_address = 32'h40; mem_read = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("midburst_resp", 64'(mem_resp), 64'd1);
    chk("midburst_rdata", mem_rdata, line_a[127:64]);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_resp", 64'(mem_resp), 64'd0);
    chk("async_rst_rdata", mem_rdata, 64'd0);
    chk("async_rst_proto_err", 64'(proto_err), 64'd0);
    mem_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Back-to-back reads with the request held; 0x2000 wraps onto line 0.
    do_line("wr0", 1'b1, 32'h0, line_d, '0, 1'b0, 1'b0);
    do_line("b2b_rd0", 1'b0, 32'h0, '0, line_d, 1'b1, 1'b0);
    do_line("b2b_rd2000", 1'b0, 32'h2000, '0, line_d, 1'b0, 1'b0);
    do_line("rd5f_final", 1'b0, 32'h5f, '0, line_a, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
